// File: rtl/hirose_msg_scheduler_if.sv
// Bundles the block, core, digest and error signals of hirose_msg_scheduler.
// slave = scheduler side, master = source/core/consumer side.
interface hirose_msg_scheduler_if #(
  parameter int DATA_WIDTH = 64
);
  logic                    blk_valid;
  logic                    blk_ready;
  logic [DATA_WIDTH-1:0]   blk_data;
  logic                    blk_last;

  logic                    core_start;
  logic [DATA_WIDTH-1:0]   core_msg;
  logic [2*DATA_WIDTH-1:0] core_h_in;
  logic                    core_done;
  logic [2*DATA_WIDTH-1:0] core_h_out;

  logic                    dig_valid;
  logic                    dig_ready;
  logic [2*DATA_WIDTH-1:0] digest;

  logic                    err;
  logic                    err_clr;

  modport slave (
    input  blk_valid, blk_data, blk_last, core_done, core_h_out, dig_ready, err_clr,
    output blk_ready, core_start, core_msg, core_h_in, dig_valid, digest, err
  );

  modport master (
    output blk_valid, blk_data, blk_last, core_done, core_h_out, dig_ready, err_clr,
    input  blk_ready, core_start, core_msg, core_h_in, dig_valid, digest, err
  );
endinterface

// File: rtl/hirose_msg_scheduler.sv
// Chains multi-block messages through one Hirose-PRESENT core and hands out the digest.
// Optional HIROSE_SCHED_BLKCNT_EN adds a saturating per-message block counter output.
module hirose_msg_scheduler #(
  parameter int                      DATA_WIDTH     = 64,
  parameter logic [2*DATA_WIDTH-1:0] IV             = {2*DATA_WIDTH{1'b0}},
  parameter int                      TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
`ifdef HIROSE_SCHED_BLKCNT_EN
  output logic [15:0] blk_count,
`endif
  hirose_msg_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUT,
    S_ERR
  } state_e;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_e                  state_q, state_d;
  logic [2*DATA_WIDTH-1:0] chain_q, chain_d;
  logic [DATA_WIDTH-1:0]   msg_q, msg_d;
  logic                    last_q, last_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    timeout_hit;

  assign timeout_hit = TIMEOUT_EN && (timer_q == TIMER_LAST);

  // NOTE: every next-state signal takes its hold value first, so no path through the
  // case statement leaves one unassigned and no latch can be inferred.
  always_comb begin
    state_d = state_q;
    chain_d = chain_q;
    msg_d   = msg_q;
    last_d  = last_q;
    timer_d = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.blk_valid) begin
          msg_d   = bus.blk_data;
          last_d  = bus.blk_last;
          state_d = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // Completion takes priority over a timeout landing on the same cycle.
        if (bus.core_done) begin
          chain_d = bus.core_h_out;
          state_d = last_q ? S_OUT : S_IDLE;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end
      S_OUT: begin
        if (bus.dig_ready) begin
          chain_d = IV;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        if (bus.err_clr) begin
          chain_d = IV;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      chain_q <= IV;
      msg_q   <= '0;
      last_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      chain_q <= chain_d;
      msg_q   <= msg_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  // Handshake outputs are forced low while reset is asserted.
  assign bus.blk_ready  = rst && (state_q == S_IDLE);
  assign bus.core_start = rst && (state_q == S_START);
  assign bus.dig_valid  = rst && (state_q == S_OUT);
  assign bus.err        = (state_q == S_ERR);
  assign bus.core_msg   = msg_q;
  assign bus.core_h_in  = chain_q;
  assign bus.digest     = chain_q;

`ifdef HIROSE_SCHED_BLKCNT_EN
  logic [15:0] blk_count_q, blk_count_d;

  always_comb begin
    blk_count_d = blk_count_q;
    if ((state_q == S_OUT && bus.dig_ready) || (state_q == S_ERR && bus.err_clr)) begin
      blk_count_d = '0;
    end else if (state_q == S_WAIT && bus.core_done && blk_count_q != 16'hFFFF) begin
      blk_count_d = blk_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      blk_count_q <= '0;
    end else begin
      blk_count_q <= blk_count_d;
    end
  end

  assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_hirose_msg_scheduler.sv
// Scoreboard bench for hirose_msg_scheduler with a behavioural compression-core model.
// Define HIROSE_SCHED_BLKCNT_EN for both RTL and bench to exercise the block counter.
module tb_hirose_msg_scheduler;
  localparam int DW  = 64;
  localparam int TMO = 16;
  localparam logic [2*DW-1:0] IV_V = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  typedef struct {
    logic [2*DW-1:0] h_in;
    logic [DW-1:0]   msg;
    logic            last;
  } job_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hirose_msg_scheduler_if #(.DATA_WIDTH(DW)) bus ();
`ifdef HIROSE_SCHED_BLKCNT_EN
  logic [15:0] blk_count;
`endif

  hirose_msg_scheduler #(
    .DATA_WIDTH    (DW),
    .IV            (IV_V),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef HIROSE_SCHED_BLKCNT_EN
    .blk_count(blk_count),
`endif
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2*DW-1:0] hfun(input logic [2*DW-1:0] h, input logic [DW-1:0] m);
    logic [DW-1:0] lo, hi;
    lo = h[DW-1:0] ^ m ^ 64'h9E37_79B9_7F4A_7C15;
    hi = h[2*DW-1:DW] + {m[31:0], m[63:32]};
    return {lo, hi};
  endfunction

  job_t            job_q[$];
  logic [2*DW-1:0] dig_q[$];
  logic [2*DW-1:0] chain_m;
  int              done_m;

  // Core model: done fires core_lat cycles after the start cycle (0 = never).
  int              core_lat;
  bit              pending;
  bit              after_done;
  int              cyc;
  job_t            cur;
  logic            model_done;
  logic [2*DW-1:0] model_h;
  logic            stray_done;
  logic [2*DW-1:0] stray_h;

  assign bus.core_done  = model_done | stray_done;
  assign bus.core_h_out = model_done ? model_h : stray_h;

  always @(negedge clk) begin
    if (!rst) begin
      pending    = 1'b0;
      after_done = 1'b0;
      model_done = 1'b0;
    end else begin
      if (after_done) begin
        after_done = 1'b0;
        if (cur.last) check("dig_latency", bus.dig_valid, 1'b1);
        else          check("rdy_latency", bus.blk_ready, 1'b1);
      end
      model_done = 1'b0;
      if (bus.core_start) begin
        if (job_q.size() == 0) begin
          check("start_unexpected", 1'b1, 1'b0);
        end else begin
          cur = job_q.pop_front();
          check("core_h_in", bus.core_h_in, cur.h_in);
          check("core_msg", bus.core_msg, cur.msg);
          pending = (core_lat != 0);
          cyc     = 0;
        end
      end else if (pending) begin
        cyc++;
        if (cyc == core_lat) begin
          check("msg_hold", bus.core_msg, cur.msg);
          model_h    = hfun(cur.h_in, cur.msg);
          model_done = 1'b1;
          pending    = 1'b0;
          after_done = 1'b1;
          done_m++;
        end
      end
    end
  end

  task automatic send_block(input logic [DW-1:0] d, input logic last);
    job_t j;
    bit   ok;
    j.h_in = chain_m;
    j.msg  = d;
    j.last = last;
    job_q.push_back(j);
    chain_m = hfun(chain_m, d);
    if (last) begin
      dig_q.push_back(chain_m);
      chain_m = IV_V;
    end
    @(posedge clk); #1;
    bus.blk_valid = 1'b1;
    bus.blk_data  = d;
    bus.blk_last  = last;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.blk_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.blk_valid = 1'b0;
    bus.blk_data  = {$urandom, $urandom};
    bus.blk_last  = 1'b0;
    if (!ok) check("accept_timeout", 1'b0, 1'b1);
    else     check("start_latency", bus.core_start, 1'b1);
  endtask

  task automatic collect(input int hold);
    bit              ok;
    logic [2*DW-1:0] held;
    logic [2*DW-1:0] exp;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.dig_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("digest_timeout", 1'b0, 1'b1);
      return;
    end
    held = bus.digest;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("digest_stable", bus.digest, held);
      check("dig_valid_hold", bus.dig_valid, 1'b1);
      check("blk_ready_in_out", bus.blk_ready, 1'b0);
    end
`ifdef HIROSE_SCHED_BLKCNT_EN
    check("blk_count_out", blk_count, done_m);
`endif
    @(posedge clk); #1;
    bus.dig_ready = 1'b1;
    @(negedge clk);
    if (dig_q.size() == 0) begin
      check("digest_unexpected", 1'b1, 1'b0);
    end else begin
      exp = dig_q.pop_front();
      check("digest", bus.digest, exp);
    end
    @(posedge clk); #1;
    bus.dig_ready = 1'b0;
    check("dig_valid_drop", bus.dig_valid, 1'b0);
    check("blk_ready_after", bus.blk_ready, 1'b1);
    check("chain_reset_iv", bus.core_h_in, IV_V);
`ifdef HIROSE_SCHED_BLKCNT_EN
    check("blk_count_clear", blk_count, 16'd0);
`endif
    done_m = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst            = 1'b0;
    bus.blk_valid  = 1'b0;
    bus.blk_data   = '0;
    bus.blk_last   = 1'b0;
    bus.dig_ready  = 1'b0;
    bus.err_clr    = 1'b0;
    stray_done     = 1'b0;
    stray_h        = '0;
    core_lat       = 10;
    chain_m        = IV_V;
    done_m         = 0;

    // Reset state, sampled while reset is still asserted after two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_blk_ready", bus.blk_ready, 1'b0);
    check("rst_core_start", bus.core_start, 1'b0);
    check("rst_dig_valid", bus.dig_valid, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_core_msg", bus.core_msg, '0);
    check("rst_chain", bus.core_h_in, IV_V);
`ifdef HIROSE_SCHED_BLKCNT_EN
    check("rst_blk_count", blk_count, 16'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_blk_ready", bus.blk_ready, 1'b1);

    // Three-block message, digest held off for 10 cycles.
    send_block(64'hAAAA_0000_1111_2222, 1'b0);
    send_block(64'hBBBB_3333_4444_5555, 1'b0);
    send_block(64'hCCCC_6666_7777_8888, 1'b1);
    collect(10);

    // Single-block message: core sees IV, blk_ready stays low until handoff.
    core_lat = 7;
    send_block(64'h0123_4567_0000_FFFF, 1'b1);
    collect(3);

    // core_done outside WAIT must not touch the chain.
    @(posedge clk); #1;
    stray_h    = {$urandom, $urandom, $urandom, $urandom};
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    check("stray_done_ignored", bus.core_h_in, IV_V);
    check("stray_done_idle", bus.blk_ready, 1'b1);

    // Timeout: core never finishes, ERR after TMO WAIT cycles.
    core_lat = 0;
    send_block(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    repeat (TMO) @(posedge clk);
    #1;
    check("err_before_timeout", bus.err, 1'b0);
    @(posedge clk); #1;
    check("err_at_timeout", bus.err, 1'b1);
    check("err_blk_ready", bus.blk_ready, 1'b0);
`ifdef HIROSE_SCHED_BLKCNT_EN
    check("err_blk_count", blk_count, 16'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", bus.err, 1'b1);
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    check("err_cleared", bus.err, 1'b0);
    check("err_clr_idle", bus.blk_ready, 1'b1);
    check("err_clr_chain", bus.core_h_in, IV_V);
    chain_m = IV_V;
    done_m  = 0;

    // Done on the last timer cycle beats the timeout.
    core_lat = TMO;
    send_block(64'h5555_AAAA_5555_AAAA, 1'b0);
    send_block(64'h0F0F_F0F0_0F0F_F0F0, 1'b1);
    collect(0);
    check("no_err_boundary", bus.err, 1'b0);

    // Shortest core latency.
    core_lat = 1;
    send_block(64'h1357_9BDF_2468_ACE0, 1'b1);
    collect(1);

    // Reset during WAIT of block 2 aborts the message.
    core_lat = 10;
    send_block(64'h7777_0000_7777_0000, 1'b0);
    send_block(64'h8888_1111_8888_1111, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_core_start", bus.core_start, 1'b0);
    check("midrst_dig_valid", bus.dig_valid, 1'b0);
    check("midrst_chain", bus.core_h_in, IV_V);
    check("midrst_err", bus.err, 1'b0);
    check("midrst_blk_ready", bus.blk_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("postrst_blk_ready", bus.blk_ready, 1'b1);
    job_q.delete();
    dig_q.delete();
    chain_m = IV_V;
    done_m  = 0;

    // Recovery message after the abort.
    core_lat = 4;
    send_block(64'h2222_3333_4444_5555, 1'b0);
    send_block(64'h6666_7777_8888_9999, 1'b1);
    collect(2);

    repeat (3) @(posedge clk);
    check("pending_jobs", job_q.size(), 0);
    check("pending_digests", dig_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
